encoder_8to3_req: RTL and testbench
===================================

// Module: encoder_8to3_req
// PURPOSE
//  Reverse of the 3-to-8 decoder: collects eight active-low request lines and
//  returns the 3-bit code {a,b,c} (a = MSB) of one request at a time.
//  Requests are latched into a pending set and served in priority order.
//  Each code is presented on a valid/ready handshake.
//  Used where decoder-style one-low lines must be turned back into a select code.
// PARAMETERS
//  PRIO_HIGH  1  1: highest index wins; 0: lowest index wins
//  EDGE_MODE  0  0: a request line held low keeps re-arming; 1: only a falling edge arms
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  en         in   1  active-high; 0 blocks new captures, pending bits keep being served
//  req_n      in   8  active-low request lines, y0..y7 order (bit i = code i)
//  a,b,c      out  1  registered code of the served request, a = MSB
//  out_valid  out  1  code is valid
//  out_ready  in   1  consumer accepts the code when out_valid && out_ready
//  any_n      out  1  0 when any pending bit or out_valid is set (combinational from regs)
//  pend_o     out  8  pending set, for debug and verification
// BEHAVIOUR
//  Reset (async, rst_n=0): pend=0, {a,b,c}=0, out_valid=0, any_n=1, req_q=8'hFF.
//  Capture: arm[i] = en & ~req_n[i] (EDGE_MODE=0)
//           or en & ~req_n[i] & req_q[i] (EDGE_MODE=1); req_q <= req_n every cycle.
//  Load condition: load = (|pend) & (~out_valid | out_ready).
//  Winner: w = priority pick over pend (PRIO_HIGH rule). It is taken from the
//   registered pend, not from this cycle's arm.
//  On load: {a,b,c} <= w; out_valid <= 1.
//  Pending update: pend <= (pend & ~clr) | arm, where clr = onehot(w) when load, else 0.
//   If arm and clr hit the same bit, set wins and the bit stays pending.
//  On handshake without load (out_valid & out_ready & ~|pend): out_valid <= 0.
//   {a,b,c} keeps its value.
//  While out_valid & ~out_ready: {a,b,c} and out_valid hold. Arming continues.
//  Latency: req_n[i] falls before edge N -> pend[i] set at N -> code valid after edge N+1,
//   if the output register is free. Back-to-back: one code per cycle while out_ready=1.
//  Duplicate requests on an already pending bit merge; nothing is counted and nothing is lost.
//  en=0 blocks arming only. req_q still tracks req_n, so a line held low across
//   the en rise does not generate an edge in EDGE_MODE=1.
//  Reset asserted mid-transfer: all state cleared at once. A code not yet accepted is dropped.
// STRUCTURE
//  Shared package enc_dec_pkg: LINES=8, CODE_W=3, and the function onehot(code)
//   (also reused by the decoder testbench).
//  One sub-module, prio_enc8 (combinational): pend[7:0], PRIO_HIGH -> w[2:0], hit.
//  Top level holds req_q, pend, the output register and the handshake logic.
// TESTING
//  1 Reset: rst_n=0 mid-run -> out_valid=0, any_n=1, pend_o=0 with no clock edge.
//  2 Single request: req_n=8'hDF pulsed 1 cycle, out_ready=1
//    -> {a,b,c}=3'b101 and out_valid two edges later, pend_o back to 0.
//  3 Priority: pend set to lines 1,4,6 together, out_ready=1.
//    PRIO_HIGH=1 -> codes 6,4,1 on consecutive cycles; PRIO_HIGH=0 -> 1,4,6.
//  4 Backpressure: out_ready=0 for 5 cycles with code 3 valid while line 7 arms
//    -> code 3 holds and pend_o=8'h80; out_ready=1 -> code 7 follows next cycle.
//  5 Set wins over clear: line 2 re-armed in the same cycle it is loaded
//    -> code 2 is issued twice.
//  6 EDGE_MODE=1: req_n[0] held low for 10 cycles -> exactly one code 0.
//    Raise en while the line is held low -> no new code.
//    EDGE_MODE=0, same stimulus -> a code 0 on every accepted cycle.

Source files
------------

// File: rtl/enc_dec_pkg.sv
// ---------------------------------------------------------------------------
// enc_dec_pkg
//   Constants and helpers shared by the 3-to-8 decoder and the 8-to-3
//   request encoder (and their testbenches).
//   LINES  : number of one-low select/request lines
//   CODE_W : width of the binary select code
//   onehot : code -> one-hot line vector (bit <code> set)
// ---------------------------------------------------------------------------
package enc_dec_pkg;

    localparam int LINES  = 8;
    localparam int CODE_W = 3;

    function automatic logic [LINES-1:0] onehot(input logic [CODE_W-1:0] code);
        logic [LINES-1:0] r;
        r       = '0;
        r[code] = 1'b1;
        return r;
    endfunction

endpackage : enc_dec_pkg

// File: rtl/prio_enc8.sv
// ---------------------------------------------------------------------------
// prio_enc8
//   Combinational priority pick over an 8-bit pending vector.
//   Parameters:
//     PRIO_HIGH : 1 -> highest set index wins, 0 -> lowest set index wins
//   Ports:
//     pend [7:0] in  : candidate bits
//     w    [2:0] out : index of the winning bit (0 when nothing is set)
//     hit        out : at least one bit of pend is set
// ---------------------------------------------------------------------------
module prio_enc8
    import enc_dec_pkg::*;
#(
    parameter bit PRIO_HIGH = 1'b1
) (
    input  logic [LINES-1:0]  pend,
    output logic [CODE_W-1:0] w,
    output logic              hit
);

    // The loop direction decides priority: the last set bit visited wins.
    always_comb begin
        w = '0;
        if (PRIO_HIGH) begin
            for (int i = 0; i < LINES; i++) begin
                if (pend[i]) w = CODE_W'(i);
            end
        end else begin
            for (int i = LINES - 1; i >= 0; i--) begin
                if (pend[i]) w = CODE_W'(i);
            end
        end
    end

    assign hit = |pend;

endmodule : prio_enc8

// File: rtl/encoder_8to3_req.sv
// ---------------------------------------------------------------------------
// encoder_8to3_req
//   Collects eight active-low request lines into a pending set and hands out
//   the 3-bit code {a,b,c} (a = MSB) of one pending request at a time, in
//   priority order, over a valid/ready output handshake.
//   Parameters:
//     PRIO_HIGH : 1 -> highest pending index served first, 0 -> lowest first
//     EDGE_MODE : 0 -> a line held low re-arms every cycle,
//                 1 -> only a falling edge (vs. last cycle's req_n) arms
//   Ports:
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     en         in   1 allows new captures; pending bits are served regardless
//     req_n[7:0] in   active-low request lines, bit i requests code i
//     a,b,c      out  registered code of the served request, a = MSB
//     out_valid  out  code on a,b,c is valid
//     out_ready  in   consumer accepts the code
//     any_n      out  0 while anything is pending or a code is presented
//     pend_o[7:0]out  pending set (debug/observability)
// ---------------------------------------------------------------------------
module encoder_8to3_req
    import enc_dec_pkg::*;
#(
    parameter bit PRIO_HIGH = 1'b1,
    parameter bit EDGE_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [LINES-1:0] req_n,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             any_n,
    output logic [LINES-1:0] pend_o
);

    logic [LINES-1:0]  req_q;
    logic [LINES-1:0]  pend;
    logic [CODE_W-1:0] code_q;
    logic              valid_q;

    logic [LINES-1:0]  arm;
    logic [LINES-1:0]  clr;
    logic [CODE_W-1:0] w;
    logic              hit;
    logic              load;

    prio_enc8 #(
        .PRIO_HIGH (PRIO_HIGH)
    ) u_prio (
        .pend (pend),
        .w    (w),
        .hit  (hit)
    );

    // In edge mode req_q masks lines that were already low last cycle.
    // req_q follows req_n even while en=0, so a line held low across the
    // en rise does not look like a fresh edge.
    assign arm = {LINES{en}} & ~req_n & (EDGE_MODE ? req_q : {LINES{1'b1}});

    // Output handshake: a code transfers on a rising edge where
    // out_valid && out_ready. The output register accepts a new code when it
    // is empty or its current code transfers in the same cycle; while
    // out_valid && !out_ready the code and out_valid hold.
    assign load = hit & (~valid_q | out_ready);

    // The winner comes from the registered pending set, so a request always
    // spends one cycle in pend before it can be issued.
    assign clr = load ? onehot(w) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= '1;
            pend    <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            req_q <= req_n;
            // Arm is OR'ed in after the clear, so a re-arm in the load cycle
            // keeps the bit pending.
            pend  <= (pend & ~clr) | arm;
            if (load) begin
                code_q  <= w;
                valid_q <= 1'b1;
            end else if (valid_q && out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign {a, b, c}  = code_q;
    assign out_valid  = valid_q;
    assign any_n      = ~((|pend) | valid_q);
    assign pend_o     = pend;

endmodule : encoder_8to3_req

// File: tb/tb_encoder_8to3_req.sv
// ---------------------------------------------------------------------------
// tb_encoder_8to3_req
//   Two encoder instances share all inputs:
//     hi : PRIO_HIGH=1, EDGE_MODE=0 (level re-arm, highest index first)
//     lo : PRIO_HIGH=0, EDGE_MODE=1 (edge arm, lowest index first)
//   Expected codes are queued per instance when stimulus is driven and
//   popped whenever that instance transfers a code.
// ---------------------------------------------------------------------------
module tb_encoder_8to3_req;
    import enc_dec_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [LINES-1:0] req_n;
    logic             out_ready;

    logic             a_hi, b_hi, c_hi, valid_hi, any_n_hi;
    logic [LINES-1:0] pend_hi;
    logic             a_lo, b_lo, c_lo, valid_lo, any_n_lo;
    logic [LINES-1:0] pend_lo;

    logic [CODE_W-1:0] exp_q_hi[$];
    logic [CODE_W-1:0] exp_q_lo[$];

    int checks = 0;
    int errors = 0;

    encoder_8to3_req #(.PRIO_HIGH(1'b1), .EDGE_MODE(1'b0)) dut_hi (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_n     (req_n),
        .a         (a_hi),
        .b         (b_hi),
        .c         (c_hi),
        .out_valid (valid_hi),
        .out_ready (out_ready),
        .any_n     (any_n_hi),
        .pend_o    (pend_hi)
    );

    encoder_8to3_req #(.PRIO_HIGH(1'b0), .EDGE_MODE(1'b1)) dut_lo (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_n     (req_n),
        .a         (a_lo),
        .b         (b_lo),
        .c         (c_lo),
        .out_valid (valid_lo),
        .out_ready (out_ready),
        .any_n     (any_n_lo),
        .pend_o    (pend_lo)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_hi();
        logic [CODE_W-1:0] e;
        if (exp_q_hi.size() == 0) begin
            check("hi_unexpected_code", 8'({a_hi, b_hi, c_hi}), 8'hEE);
        end else begin
            e = exp_q_hi.pop_front();
            check("hi_code", 8'({a_hi, b_hi, c_hi}), 8'(e));
        end
    endtask

    task automatic pop_lo();
        logic [CODE_W-1:0] e;
        if (exp_q_lo.size() == 0) begin
            check("lo_unexpected_code", 8'({a_lo, b_lo, c_lo}), 8'hEE);
        end else begin
            e = exp_q_lo.pop_front();
            check("lo_code", 8'({a_lo, b_lo, c_lo}), 8'(e));
        end
    endtask

    // Inputs are final when tick is called, so out_valid && out_ready here
    // is exactly the transfer that happens on the coming edge. Returns 1ns
    // after the edge, which is where stimulus changes and checks sample.
    task automatic tick();
        if (valid_hi && out_ready) pop_hi();
        if (valid_lo && out_ready) pop_lo();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_both(input logic [CODE_W-1:0] code);
        exp_q_hi.push_back(code);
        exp_q_lo.push_back(code);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        req_n     = 8'hFF;
        out_ready = 1'b1;
        ticks(2);

        // reset state
        check("rst_valid_hi", 8'(valid_hi), 8'h00);
        check("rst_any_n_hi", 8'(any_n_hi), 8'h01);
        check("rst_pend_hi",  pend_hi, 8'h00);
        check("rst_code_hi",  8'({a_hi, b_hi, c_hi}), 8'h00);
        check("rst_pend_lo",  pend_lo, 8'h00);
        rst_n = 1'b1;
        ticks(2);

        // single request on line 5, one-cycle pulse
        req_n = 8'hDF;
        push_both(3'd5);
        tick();
        req_n = 8'hFF;
        check("single_pend_n", pend_hi, 8'h20);
        check("single_valid_n", 8'(valid_hi), 8'h00);
        tick();
        check("single_valid_n1_hi", 8'(valid_hi), 8'h01);
        check("single_code_n1_hi", 8'({a_hi, b_hi, c_hi}), 8'h05);
        check("single_valid_n1_lo", 8'(valid_lo), 8'h01);
        check("single_pend_n1", pend_hi, 8'h00);
        tick();
        check("single_idle_valid", 8'(valid_hi), 8'h00);
        check("single_idle_any_n", 8'(any_n_hi), 8'h01);
        ticks(1);

        // priority: lines 1,4,6 together
        req_n = ~8'b0101_0010;
        exp_q_hi.push_back(3'd6);
        exp_q_hi.push_back(3'd4);
        exp_q_hi.push_back(3'd1);
        exp_q_lo.push_back(3'd1);
        exp_q_lo.push_back(3'd4);
        exp_q_lo.push_back(3'd6);
        tick();
        req_n = 8'hFF;
        check("prio_pend_hi", pend_hi, 8'h52);
        check("prio_pend_lo", pend_lo, 8'h52);
        tick();
        check("prio_first_pend_hi", pend_hi, 8'h12);
        check("prio_first_pend_lo", pend_lo, 8'h50);
        check("prio_any_n", 8'(any_n_hi), 8'h00);
        tick();
        check("prio_second_code_hi", 8'({a_hi, b_hi, c_hi}), 8'h04);
        ticks(4);

        // backpressure: code 3 held while line 7 arms
        out_ready = 1'b0;
        req_n = 8'hF7;
        push_both(3'd3);
        tick();
        req_n = 8'hFF;
        tick();
        req_n = 8'h7F;
        push_both(3'd7);
        tick();
        req_n = 8'hFF;
        check("bp_code_hi", 8'({a_hi, b_hi, c_hi}), 8'h03);
        check("bp_pend_hi", pend_hi, 8'h80);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_valid", 8'(valid_hi), 8'h01);
            check("bp_hold_code", 8'({a_lo, b_lo, c_lo}), 8'h03);
            check("bp_hold_pend", pend_lo, 8'h80);
        end
        out_ready = 1'b1;
        tick();
        check("bp_next_code_hi", 8'({a_hi, b_hi, c_hi}), 8'h07);
        check("bp_next_valid_lo", 8'(valid_lo), 8'h01);
        check("bp_next_pend_hi", pend_hi, 8'h00);
        ticks(2);

        // set wins over clear: line 2 still low in its load cycle
        req_n = 8'hFB;
        push_both(3'd2);
        tick();
        exp_q_hi.push_back(3'd2);   // level mode re-arms; edge mode does not
        tick();
        req_n = 8'hFF;
        check("setwin_pend_hi", pend_hi, 8'h04);
        check("setwin_pend_lo", pend_lo, 8'h00);
        check("setwin_code_hi", 8'({a_hi, b_hi, c_hi}), 8'h02);
        ticks(4);

        // line 0 held low for 10 cycles
        req_n = 8'hFE;
        push_both(3'd0);
        for (int i = 0; i < 9; i++) exp_q_hi.push_back(3'd0);
        ticks(5);
        check("hold_pend_hi", pend_hi, 8'h01);
        check("hold_pend_lo", pend_lo, 8'h00);
        ticks(5);
        req_n = 8'hFF;
        ticks(4);
        check("hold_drained_hi", 8'(any_n_hi), 8'h01);

        // line held low across the en rise
        en    = 1'b0;
        req_n = 8'hFE;
        ticks(3);
        check("en_block_hi", pend_hi, 8'h00);
        check("en_block_lo", pend_lo, 8'h00);
        en = 1'b1;
        for (int i = 0; i < 4; i++) exp_q_hi.push_back(3'd0);
        ticks(4);
        req_n = 8'hFF;
        ticks(4);
        check("en_rise_any_n_lo", 8'(any_n_lo), 8'h01);

        // reset asserted mid-transfer drops everything, no clock edge needed
        out_ready = 1'b0;
        req_n = 8'hE7;
        tick();
        req_n = 8'hFF;
        tick();
        check("midrst_busy_any_n", 8'(any_n_hi), 8'h00);
        rst_n = 1'b0;
        #2;
        check("midrst_valid_hi", 8'(valid_hi), 8'h00);
        check("midrst_any_n_hi", 8'(any_n_hi), 8'h01);
        check("midrst_pend_hi",  pend_hi, 8'h00);
        check("midrst_valid_lo", 8'(valid_lo), 8'h00);
        check("midrst_pend_lo",  pend_lo, 8'h00);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        ticks(3);
        check("post_rst_valid_hi", 8'(valid_hi), 8'h00);

        // every queued code must have been issued
        check("hi_queue_empty", 8'(exp_q_hi.size()), 8'h00);
        check("lo_queue_empty", 8'(exp_q_lo.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_encoder_8to3_req
